// File: rtl/cpu_core_p.sv
// cpu_core_p: parametrised multi-cycle 16-bit-instruction CPU core.
// Fetches instruction words over a req/valid handshake. Register, immediate,
// direct and branch forms run on an 8 x DW register file. Provides carry flag,
// stores, conditional branches, HALT/illegal handling and debug readout.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   en                       run enable, sampled only in S_FETCH
//   imem_req/addr/rdata/valid  instruction fetch handshake
//   dmem_req/we/addr/wdata/rdata/valid  data memory handshake
//   za, zb, eq, gt, lt, cy   ALU flags
//   alu_out                  last ALU result
//   pc                       program counter
//   halted, err              stop indication, sticky illegal-instruction flag
//   dbg_sel, dbg_data        combinational register readout
module cpu_core_p #(
  parameter int DW  = 16,
  parameter int PAW = 8,
  parameter int DAW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  output logic           imem_req,
  output logic [PAW-1:0] imem_addr,
  input  logic [15:0]    imem_rdata,
  input  logic           imem_valid,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [DAW-1:0] dmem_addr,
  output logic [DW-1:0]  dmem_wdata,
  input  logic [DW-1:0]  dmem_rdata,
  input  logic           dmem_valid,
  output logic           za,
  output logic           zb,
  output logic           eq,
  output logic           gt,
  output logic           lt,
  output logic           cy,
  output logic [DW-1:0]  alu_out,
  output logic [PAW-1:0] pc,
  output logic           halted,
  output logic           err,
  input  logic [2:0]     dbg_sel,
  output logic [DW-1:0]  dbg_data
);

  typedef enum logic [2:0] {S_FETCH, S_OPND, S_MEM, S_EXEC, S_HALT} state_t;

  localparam logic [DW:0] ONE_W = (DW+1)'(1);

  state_t          state_reg, state_next;
  logic [PAW-1:0]  pc_reg;
  logic [15:0]     ir_reg;
  logic [15:0]     opnd_reg;
  logic [DW-1:0]   mem_data_reg;
  logic [DW-1:0]   rf_reg [8];
  logic [DW-1:0]   alu_out_reg;
  logic [5:0]      flags_reg;   // {za, zb, eq, gt, lt, cy}
  logic            halted_reg;
  logic            err_reg;

  // Decode helpers shared by the fetch-time routing and the execute stage.
  function automatic logic is_legal(input logic [15:0] w);
    logic [1:0] m;
    logic [1:0] t;
    logic [3:0] o;
    m = w[15:14];
    t = w[13:12];
    o = w[11:8];
    is_legal = 1'b0;
    if (m != 2'b11) begin
      case (t)
        2'b00:   is_legal = (o == 4'h0) || (o == 4'h1 && m == 2'b10);
        2'b01:   is_legal = (o <= 4'h4);
        2'b10:   is_legal = (o <= 4'h5);
        default: is_legal = (o == 4'hF) || (o <= 4'h3 && m == 2'b01);
      endcase
    end
  endfunction

  function automatic logic is_halt(input logic [15:0] w);
    is_halt = (w[15:14] != 2'b11) && (w[13:12] == 2'b11) && (w[11:8] == 4'hF);
  endfunction

  // Illegal words and HALT skip the operand fetch and go straight to execute.
  function automatic logic needs_opnd(input logic [15:0] w);
    needs_opnd = is_legal(w) && !is_halt(w) && (w[15:14] != 2'b00);
  endfunction

  logic [1:0]    mode;
  logic [1:0]    typ;
  logic [3:0]    opc;
  logic [2:0]    rd_idx;
  logic [2:0]    rs_idx;
  logic          legal;
  logic          exec_stop;
  logic          is_store;
  logic          is_alu;
  logic          wr_en;
  logic          br_taken;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [DW:0]   wide;
  logic [DW-1:0] wb_data;

  assign mode      = ir_reg[15:14];
  assign typ       = ir_reg[13:12];
  assign opc       = ir_reg[11:8];
  assign rd_idx    = ir_reg[7:5];
  assign rs_idx    = ir_reg[4:2];
  assign legal     = is_legal(ir_reg);
  assign exec_stop = !legal || is_halt(ir_reg);
  assign is_store  = legal && (typ == 2'b00) && (opc == 4'h1);
  assign is_alu    = legal && (typ == 2'b01 || typ == 2'b10);

  // Operand selection and ALU.
  always_comb begin
    op_a     = rf_reg[rd_idx];
    op_b     = rf_reg[rs_idx];
    wide     = '0;
    wr_en    = 1'b0;
    br_taken = 1'b0;
    wb_data  = op_b;
    case (mode)
      2'b01:   op_b = DW'(opnd_reg);
      2'b10:   op_b = mem_data_reg;
      default: op_b = rf_reg[rs_idx];
    endcase
    if (typ == 2'b01) begin
      case (opc)
        4'h0:    wide = {1'b0, op_a} + {1'b0, op_b};
        4'h1:    wide = {1'b0, op_a} - {1'b0, op_b};
        4'h2:    wide = {1'b0, op_a} + ONE_W;
        4'h3:    wide = {1'b0, op_a} - ONE_W;
        4'h4:    wide = {1'b0, op_a} - {1'b0, op_b};
        default: wide = '0;
      endcase
    end else if (typ == 2'b10) begin
      // Top bit of wide carries the shifted-out bit; zero for bitwise ops.
      case (opc)
        4'h0:    wide = {1'b0, op_a & op_b};
        4'h1:    wide = {1'b0, op_a | op_b};
        4'h2:    wide = {1'b0, op_a ^ op_b};
        4'h3:    wide = {1'b0, ~op_a};
        4'h4:    wide = {op_a, 1'b0};
        4'h5:    wide = {op_a[0], 1'b0, op_a[DW-1:1]};
        default: wide = '0;
      endcase
    end
    if (legal && typ == 2'b00 && opc == 4'h0) begin
      wr_en   = 1'b1;
      wb_data = op_b;
    end else if (is_alu && !(typ == 2'b01 && opc == 4'h4)) begin
      wr_en   = 1'b1;
      wb_data = wide[DW-1:0];
    end
    if (legal && typ == 2'b11) begin
      case (opc)
        4'h0:    br_taken = 1'b1;
        4'h1:    br_taken = flags_reg[3];
        4'h2:    br_taken = flags_reg[2];
        4'h3:    br_taken = flags_reg[1];
        default: br_taken = 1'b0;
      endcase
    end
  end

  // Next-state and handshake outputs. Requests are forced low during reset.
  always_comb begin
    state_next = state_reg;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    case (state_reg)
      S_FETCH: begin
        if (en) begin
          imem_req = 1'b1;
          if (imem_valid)
            state_next = needs_opnd(imem_rdata) ? S_OPND : S_EXEC;
        end
      end
      S_OPND: begin
        imem_req = 1'b1;
        if (imem_valid)
          state_next = (mode == 2'b10) ? S_MEM : S_EXEC;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_valid)
          state_next = S_EXEC;
      end
      S_EXEC:  state_next = exec_stop ? S_HALT : S_FETCH;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
    if (rst) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_FETCH;
      pc_reg       <= '0;
      ir_reg       <= '0;
      opnd_reg     <= '0;
      mem_data_reg <= '0;
      alu_out_reg  <= '0;
      flags_reg    <= '0;
      halted_reg   <= 1'b0;
      err_reg      <= 1'b0;
      for (int i = 0; i < 8; i++) rf_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_FETCH: begin
          if (en && imem_valid) begin
            ir_reg <= imem_rdata;
            pc_reg <= pc_reg + PAW'(1);
          end
        end
        S_OPND: begin
          if (imem_valid) begin
            opnd_reg <= imem_rdata;
            pc_reg   <= pc_reg + PAW'(1);
          end
        end
        S_MEM: begin
          if (dmem_valid) mem_data_reg <= dmem_rdata;
        end
        S_EXEC: begin
          if (wr_en) rf_reg[rd_idx] <= wb_data;
          if (is_alu) begin
            alu_out_reg <= wide[DW-1:0];
            flags_reg   <= {op_a == '0, op_b == '0, op_a == op_b,
                            op_a > op_b, op_a < op_b, wide[DW]};
          end
          if (br_taken) pc_reg <= opnd_reg[PAW-1:0];
          if (exec_stop) begin
            halted_reg <= 1'b1;
            err_reg    <= err_reg | !legal;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = pc_reg;
  assign dmem_addr  = opnd_reg[DAW-1:0];
  assign dmem_wdata = rf_reg[rd_idx];
  assign {za, zb, eq, gt, lt, cy} = flags_reg;
  assign alu_out    = alu_out_reg;
  assign pc         = pc_reg;
  assign halted     = halted_reg;
  assign err        = err_reg;
  assign dbg_data   = rf_reg[dbg_sel];

  // Instruction bits [1:0] and operand bits above the used widths are don't-care.
  logic unused_bits;
  assign unused_bits = ^{ir_reg, opnd_reg};

endmodule

// File: tb/tb_cpu_core_p.sv
module tb_cpu_core_p;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic        imem_req, imem_valid;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_valid;
  logic [7:0]  dmem_addr;
  logic [15:0] dmem_wdata, dmem_rdata;
  logic        za, zb, eq, gt, lt, cy, halted, err;
  logic [15:0] alu_out, dbg_data;
  logic [7:0]  pc;
  logic [2:0]  dbg_sel = 3'd0;

  // Second core with a 4-bit PC for the wrap-around case.
  logic        imem_req2, dmem_req2, dmem_we2;
  logic [3:0]  imem_addr2, pc2;
  logic [7:0]  dmem_addr2;
  logic [15:0] imem_rdata2, dmem_wdata2, alu_out2, dbg_data2;
  logic        za2, zb2, eq2, gt2, lt2, cy2, halted2, err2;
  logic [2:0]  dbg_sel2 = 3'd4;

  logic [15:0] imem  [256];
  logic [15:0] imem2 [16];
  logic [15:0] dmem  [256];
  int i_wait = 0, d_wait = 0, icnt = 0, dcnt = 0;
  int total = 0, bad = 0;
  int dreq_cycles = 0, dchg = 0;
  logic        d_hold = 1'b0;
  logic [7:0]  d_addr_q;
  logic [15:0] d_wdata_q;

  always #5 clk = ~clk;

  cpu_core_p #(.DW(16), .PAW(8), .DAW(8)) dut (
    .clk(clk), .rst(rst), .en(en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_valid(dmem_valid),
    .za(za), .zb(zb), .eq(eq), .gt(gt), .lt(lt), .cy(cy),
    .alu_out(alu_out), .pc(pc), .halted(halted), .err(err),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  cpu_core_p #(.DW(16), .PAW(4), .DAW(8)) dut2 (
    .clk(clk), .rst(rst), .en(en),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2), .imem_valid(imem_req2),
    .dmem_req(dmem_req2), .dmem_we(dmem_we2), .dmem_addr(dmem_addr2), .dmem_wdata(dmem_wdata2),
    .dmem_rdata(16'h0000), .dmem_valid(dmem_req2),
    .za(za2), .zb(zb2), .eq(eq2), .gt(gt2), .lt(lt2), .cy(cy2),
    .alu_out(alu_out2), .pc(pc2), .halted(halted2), .err(err2),
    .dbg_sel(dbg_sel2), .dbg_data(dbg_data2)
  );

  // Memory models: valid after a programmable number of withheld cycles.
  assign imem_valid  = imem_req && (icnt >= i_wait);
  assign imem_rdata  = imem[imem_addr];
  assign imem_rdata2 = imem2[imem_addr2];
  assign dmem_valid  = dmem_req && (dcnt >= d_wait);
  assign dmem_rdata  = dmem[dmem_addr];

  always @(posedge clk) begin
    if (!imem_req || imem_valid) icnt <= 0; else icnt <= icnt + 1;
    if (!dmem_req || dmem_valid) dcnt <= 0; else dcnt <= dcnt + 1;
    if (dmem_req && dmem_we && dmem_valid) dmem[dmem_addr] <= dmem_wdata;
    if (dmem_req) begin
      dreq_cycles++;
      if (d_hold && (dmem_addr != d_addr_q || dmem_wdata != d_wdata_q)) dchg++;
    end
    d_hold    = dmem_req && !dmem_valid;
    d_addr_q  = dmem_addr;
    d_wdata_q = dmem_wdata;
  end

  typedef struct {
    logic [15:0] instr;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_r1;
    logic [15:0] exp_alu;
    logic [5:0]  exp_flags;
  } vec_t;
  vec_t vecs [13];

  function automatic logic [15:0] enc(input logic [1:0] m, input logic [1:0] t,
                                      input logic [3:0] o, input logic [2:0] rd,
                                      input logic [2:0] rs);
    return {m, t, o, rd, rs, 2'b00};
  endfunction

  localparam logic [15:0] HALT_W = 16'h3F00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = HALT_W;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_to_halt(input string name, output int cycles);
    cycles = 0;
    while (!halted && cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk({name, "_halt_reached"}, halted, 1'b1);
  endtask

  task automatic read_reg(input logic [2:0] s, output logic [15:0] v);
    dbg_sel = s;
    #1 v = dbg_data;
  endtask

  task automatic mov_imm(input int addr, input logic [2:0] rd, input logic [15:0] val);
    imem[addr]     = enc(2'd1, 2'd0, 4'h0, rd, 3'd0);
    imem[addr + 1] = val;
  endtask

  initial begin
    logic [15:0] v;
    int cyc, viol, base_req, base_chg;

    for (int i = 0; i < 16; i++) imem2[i] = HALT_W;
    imem2[0]  = enc(2'd1, 2'd3, 4'h0, 3'd0, 3'd0);   // JMP #15
    imem2[1]  = 16'h000F;
    imem2[15] = enc(2'd1, 2'd0, 4'h0, 3'd4, 3'd0);   // MOV R4,# ; word at wrapped addr 0

    // ---- reset mid-fetch with instruction wait states ----
    clear_imem();
    mov_imm(0, 3'd1, 16'h0005);
    mov_imm(2, 3'd2, 16'h0003);
    i_wait = 2;
    do_reset();
    repeat (9) @(posedge clk);
    #1;
    read_reg(3'd1, v);
    chk("pre_rst_r1", v, 16'h0005);
    chk("pre_rst_pc", pc, 8'h02);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    read_reg(3'd1, v);
    chk("rst_r1", v, 16'h0000);
    chk("rst_pc", pc, 8'h00);
    chk("rst_req", {imem_req, dmem_req, dmem_we}, 3'b000);
    chk("rst_flags", {za, zb, eq, gt, lt, cy}, 6'b000000);
    chk("rst_alu", alu_out, 16'h0000);
    chk("rst_halt_err", {halted, err}, 2'b00);
    rst = 1'b0;
    #1;
    chk("rel_req_addr", {imem_req, imem_addr}, {1'b1, 8'h00});
    i_wait = 0;

    // ---- MOV/ADD timing, then HALT behaviour ----
    clear_imem();
    mov_imm(0, 3'd1, 16'h0005);
    mov_imm(2, 3'd2, 16'h0003);
    imem[4] = enc(2'd0, 2'd1, 4'h0, 3'd1, 3'd2);
    do_reset();
    repeat (7) @(posedge clk);
    #1 chk("add_alu_c7", alu_out, 16'h0000);
    @(posedge clk);
    #1 chk("add_alu_c8", alu_out, 16'h0008);
    read_reg(3'd1, v);
    chk("add_r1", v, 16'h0008);
    chk("add_gt_cy", {gt, cy}, 2'b10);
    run_to_halt("add", cyc);
    chk("halt_err", err, 1'b0);
    chk("halt_pc", pc, 8'h06);
    viol = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (imem_req || dmem_req) viol++;
    end
    chk("halt_noreq", viol, 0);

    // ---- table-driven ALU vectors: MOV R1,#a; MOV R2,#b; op R1,R2; HALT ----
    vecs[0]  = '{enc(2'd0, 2'd1, 4'h0, 3'd1, 3'd2), 16'h0005, 16'h0003, 16'h0008, 16'h0008, 6'b000100};
    vecs[1]  = '{enc(2'd0, 2'd1, 4'h1, 3'd1, 3'd2), 16'h0000, 16'h0001, 16'hFFFF, 16'hFFFF, 6'b100011};
    vecs[2]  = '{enc(2'd0, 2'd1, 4'h0, 3'd1, 3'd2), 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 6'b000101};
    vecs[3]  = '{enc(2'd0, 2'd1, 4'h2, 3'd1, 3'd2), 16'h0007, 16'h0000, 16'h0008, 16'h0008, 6'b010100};
    vecs[4]  = '{enc(2'd0, 2'd1, 4'h3, 3'd1, 3'd2), 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 6'b111001};
    vecs[5]  = '{enc(2'd0, 2'd1, 4'h4, 3'd1, 3'd2), 16'h0009, 16'h0009, 16'h0009, 16'h0000, 6'b001000};
    vecs[6]  = '{enc(2'd0, 2'd2, 4'h0, 3'd1, 3'd2), 16'hF0F0, 16'h3C3C, 16'h3030, 16'h3030, 6'b000100};
    vecs[7]  = '{enc(2'd0, 2'd2, 4'h1, 3'd1, 3'd2), 16'h00F0, 16'h0F00, 16'h0FF0, 16'h0FF0, 6'b000010};
    vecs[8]  = '{enc(2'd0, 2'd2, 4'h2, 3'd1, 3'd2), 16'hAAAA, 16'hAAAA, 16'h0000, 16'h0000, 6'b001000};
    vecs[9]  = '{enc(2'd0, 2'd2, 4'h3, 3'd1, 3'd2), 16'h00FF, 16'h0000, 16'hFF00, 16'hFF00, 6'b010100};
    vecs[10] = '{enc(2'd0, 2'd2, 4'h4, 3'd1, 3'd2), 16'h8001, 16'h0001, 16'h0002, 16'h0002, 6'b000101};
    vecs[11] = '{enc(2'd0, 2'd2, 4'h5, 3'd1, 3'd2), 16'h0003, 16'h0005, 16'h0001, 16'h0001, 6'b000011};
    vecs[12] = '{enc(2'd0, 2'd0, 4'h0, 3'd1, 3'd2), 16'h0001, 16'h0002, 16'h0002, 16'h0000, 6'b000000};
    for (int i = 0; i < 13; i++) begin
      clear_imem();
      mov_imm(0, 3'd1, vecs[i].a);
      mov_imm(2, 3'd2, vecs[i].b);
      imem[4] = vecs[i].instr;
      do_reset();
      run_to_halt($sformatf("v%0d", i), cyc);
      read_reg(3'd1, v);
      chk($sformatf("v%0d_r1", i), v, vecs[i].exp_r1);
      chk($sformatf("v%0d_alu", i), alu_out, vecs[i].exp_alu);
      chk($sformatf("v%0d_flags", i), {za, zb, eq, gt, lt, cy}, vecs[i].exp_flags);
      $display("vector %0d instr=%h a=%h b=%h r1=%h alu=%h", i, vecs[i].instr, vecs[i].a, vecs[i].b, v, alu_out);
    end

    // ---- direct store/load with 3 withheld dmem cycles ----
    clear_imem();
    mov_imm(0, 3'd1, 16'h1234);
    imem[2] = enc(2'd2, 2'd0, 4'h1, 3'd1, 3'd0);   // STORE R1,[0x20]
    imem[3] = 16'h0020;
    imem[4] = enc(2'd2, 2'd0, 4'h0, 3'd3, 3'd0);   // MOV R3,[0x20]
    imem[5] = 16'h0020;
    d_wait = 3;
    base_req = dreq_cycles;
    base_chg = dchg;
    do_reset();
    run_to_halt("ldst", cyc);
    chk("ldst_cycles", cyc, 19);
    chk("ldst_dmem", dmem[8'h20], 16'h1234);
    read_reg(3'd3, v);
    chk("ldst_r3", v, 16'h1234);
    chk("ldst_req_cycles", dreq_cycles - base_req, 8);
    chk("ldst_stable", dchg - base_chg, 0);
    d_wait = 0;

    // ---- taken JEQ ----
    clear_imem();
    mov_imm(0, 3'd1, 16'h0007);
    mov_imm(2, 3'd2, 16'h0007);
    imem[4] = enc(2'd0, 2'd1, 4'h4, 3'd1, 3'd2);   // CMP
    imem[5] = enc(2'd1, 2'd3, 4'h1, 3'd0, 3'd0);   // JEQ #0x40
    imem[6] = 16'h0040;
    imem[7] = enc(2'd0, 2'd1, 4'h2, 3'd1, 3'd0);   // INC R1, skipped when taken
    do_reset();
    run_to_halt("jeq_t", cyc);
    chk("jeq_t_pc", pc, 8'h41);
    chk("jeq_t_cycles", cyc, 13);
    read_reg(3'd1, v);
    chk("jeq_t_r1", v, 16'h0007);

    // ---- untaken JEQ, then taken JLT ----
    clear_imem();
    mov_imm(0, 3'd1, 16'h0001);
    mov_imm(2, 3'd2, 16'h0002);
    imem[4] = enc(2'd0, 2'd1, 4'h4, 3'd1, 3'd2);
    imem[5] = enc(2'd1, 2'd3, 4'h1, 3'd0, 3'd0);   // JEQ #0x40 (not taken)
    imem[6] = 16'h0040;
    imem[7] = enc(2'd1, 2'd3, 4'h3, 3'd0, 3'd0);   // JLT #0x30 (taken)
    imem[8] = 16'h0030;
    do_reset();
    repeat (11) @(posedge clk);
    #1 chk("jeq_nt_pc", pc, 8'h07);
    run_to_halt("jlt", cyc);
    chk("jlt_pc", pc, 8'h31);

    // ---- illegal encodings ----
    clear_imem();
    imem[0] = 16'hC000;
    do_reset();
    run_to_halt("ill_c000", cyc);
    chk("ill_c000_err", err, 1'b1);
    chk("ill_c000_cycles", cyc, 2);
    clear_imem();
    mov_imm(0, 3'd1, 16'h0009);
    imem[2] = enc(2'd0, 2'd1, 4'h7, 3'd1, 3'd2);   // unlisted arithmetic opcode
    do_reset();
    chk("ill_err_cleared", err, 1'b0);
    run_to_halt("ill_op", cyc);
    chk("ill_op_err", err, 1'b1);
    read_reg(3'd1, v);
    chk("ill_op_nowb", v, 16'h0009);
    clear_imem();
    imem[0] = enc(2'd0, 2'd0, 4'h1, 3'd1, 3'd0);   // STORE in register mode
    do_reset();
    run_to_halt("ill_st", cyc);
    chk("ill_st_err", err, 1'b1);

    // ---- run enable ----
    clear_imem();
    mov_imm(0, 3'd1, 16'h0077);
    en = 1'b0;
    do_reset();
    viol = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (imem_req) viol++;
    end
    chk("en0_noreq", viol, 0);
    chk("en0_pc", pc, 8'h00);
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    read_reg(3'd1, v);
    chk("en_mid_r1", v, 16'h0077);
    chk("en_mid_hold", {imem_req, pc, halted}, {1'b0, 8'h02, 1'b0});
    en = 1'b1;
    run_to_halt("en_resume", cyc);

    // ---- PC wrap on the PAW=4 core (ran alongside since the last reset) ----
    repeat (20) @(posedge clk);
    #1;
    chk("wrap_halted", {halted2, err2}, 2'b10);
    chk("wrap_pc", pc2, 4'h3);
    chk("wrap_r4", dbg_data2, 16'h7000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_core_p.md
# cpu_core_p

Parametrised multi-cycle CPU core for the 16-bit CPU project. It is the next generation of the fixed-width ROM/RAM/ALU top level. It fetches 16-bit instruction words over a valid/req memory handshake, decodes them into register, immediate, direct and branch forms, and executes them on an 8-entry register file of DW-bit data. It adds the following over the previous core:
- wait-state tolerant instruction and data memory ports
- stores to data RAM
- conditional branches
- a carry flag
- HALT and illegal-instruction handling
- register debug readout

## Interface
Parameters:
- DW, 16: data width of registers, ALU and dmem data; legal range 8..32.
- PAW, 8: program address width; the PC wraps modulo 2^PAW.
- DAW, 8: data RAM address width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- en  in  1  run enable; sampled only in S_FETCH.
- imem_req  out  1  instruction read request.
- imem_addr  out  PAW  instruction word address.
- imem_rdata  in  16  instruction word.
- imem_valid  in  1  instruction word valid.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = write, 0 = read; qualified by dmem_req.
- dmem_addr  out  DAW  data address.
- dmem_wdata  out  DW  write data.
- dmem_rdata  in  DW  read data.
- dmem_valid  in  1  read data valid / write acknowledge.
- za, zb, eq, gt, lt, cy  out  1 each  ALU flags.
- alu_out  out  DW  last ALU result.
- pc  out  PAW  current PC.
- halted  out  1  core stopped.
- err  out  1  sticky; set by an illegal instruction.
- dbg_sel  in  3  register select.
- dbg_data  out  DW  combinational read of R[dbg_sel].

## Operation
- **Instruction word:** [15:14] mode (00 reg, 01 imm, 10 direct, 11 illegal); [13:12] type; [11:8] opcode; [7:5] rd (op1); [4:2] rs (op2); [1:0] ignored.
- **Second word:** imm and direct modes fetch one extra word at pc+1.
  - imm: the word is zero-extended or truncated to DW and used as op2.
  - direct: the word's low DAW bits are the data address. For loads, op2 = dmem_rdata.
- **Type 00, move:**
  - 0000 MOV: rd <= op2.
  - 0001 STORE (direct only): dmem[addr] <= rd.
- **Type 01, arithmetic:**
  - 0000 ADD, 0001 SUB: rd <= rd op op2, modulo 2^DW. cy = carry out for ADD, borrow for SUB.
  - 0010 INC, 0011 DEC: operate on rd.
  - 0100 CMP: flags only, no writeback.
- **Type 10, logic:** 0000 AND, 0001 OR, 0010 XOR, 0011 NOT rd, 0100 SHL by 1, 0101 SHR by 1 (logical). cy = bit shifted out; cy = 0 for the other logic ops.
- **Type 11, control (imm only):**
  - 0000 JMP, 0001 JEQ, 0010 JGT, 0011 JLT.
  - Target = low PAW bits of the immediate word.
  - Conditions use the current eq/gt/lt flags.
  - 1111 HALT; any mode.
- **Flags:** arithmetic and logic instructions update all six flags. za = (rd operand == 0), zb = (op2 == 0), and eq/gt/lt compare rd operand against op2, unsigned. Move and control instructions leave the flags and alu_out unchanged.
- **Illegal instructions:** any unlisted encoding, mode 11, STORE not in direct mode, or control not in imm mode. Effect: err <= 1 and halted <= 1, with no writeback.
- **FSM states:** S_FETCH -> S_OPND (imm/direct) -> S_MEM (direct) -> S_EXEC -> S_FETCH. S_HALT is terminal until rst.
  - S_FETCH: if en = 0, hold with imem_req = 0. Otherwise assert imem_req with imem_addr = pc. When imem_valid is high, capture IR and pc <= pc+1.
  - S_OPND: request the word at pc. On valid, capture it and pc <= pc+1.
  - S_MEM: issue dmem_req, with dmem_we = 1 for STORE, and wait for dmem_valid.
  - S_EXEC: write rd, update flags and alu_out, take any branch (pc <= target). Next state is S_FETCH, or S_HALT.
- **Register-mode skip:** register-mode instructions go straight from S_FETCH to S_EXEC on the cycle after capture.

## Timing
- **Reset values:** pc = 0, R0..R7 = 0, all flags 0, alu_out = 0, halted = 0, err = 0, all req/we = 0. The state is S_FETCH.
- **Reset mid-handshake:** requests drop in the cycle after rst is sampled, and a late valid is ignored.
- **Handshake:**
  - req rises with the address/wdata stable and stays high until the cycle valid is sampled high. Zero-wait is allowed: valid in the same cycle as req.
  - req drops the cycle after acceptance, unless the next state issues a new request.
  - valid while req = 0 is ignored.
- **Cycles per instruction, zero-wait memory:** reg 2, imm 3, direct 4, HALT 2. Each cycle valid is withheld adds one cycle.
- **Visibility:** results appear on rd, alu_out and the flags one edge after S_EXEC, so back-to-back dependent instructions need no stall.
- **en:** deasserting en mid-instruction finishes the current instruction and then holds in S_FETCH.
- **PC wrap:** the PC wraps from 2^PAW-1 to 0, including between the first and second word of an instruction.
- **Halted state:** halted = 1 from the edge leaving S_EXEC. All req signals stay 0 while halted.

## Test plan
- **Reset:** assert rst for 2 cycles mid-fetch -> outputs match the reset values, and imem_req = 1 with addr 0 on the first cycle after rst falls.
- **MOV/ADD:** MOV R1,#5; MOV R2,#3; ADD R1,R2 with zero-wait memory -> R1 = 8, alu_out = 8, gt = 1, cy = 0, and the ADD completes 8 cycles after reset release.
- **SUB borrow (DW = 16):** R1 = 0 SUB R2 = 1 -> R1 = 0xFFFF, cy = 1, lt = 1, za = 1, zb = 0.
- **Direct load/store with wait states:** STORE R1 to 0x20, then load 0x20 into R3, with dmem_valid delayed 3 cycles each -> dmem_addr/wdata are stable for 4 cycles, R3 = R1, and each instruction takes 7 cycles.
- **Branches and PC wrap:** CMP equal operands, then JEQ 0x40 -> pc = 0x40. With eq = 0, JEQ -> pc = address+2. With PAW = 4, an imm instruction at address 15 fetches its second word from address 0.
- **HALT, illegal instruction, en:**
  - HALT -> halted = 1, err = 0, no further imem_req.
  - Encoding 0xC000 -> halted = 1, err = 1.
  - en = 0 -> the core holds at S_FETCH with imem_req = 0.
